// File: rtl/alu_pkg.sv
// Shared ALU definitions: default adder geometry and the flag bundle
// consumed by the result mux.
package alu_pkg;

    localparam int ADDER_WIDTH = 16;
    localparam int ADDER_CHUNK = 4;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } adder_flags_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB
// so the top slice can derive signed overflow.
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    assign cout  = carry[CHUNK];
    assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full-adder cell, the building block of every ripple slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: one CHUNK-bit slice is resolved per stage so
// the per-cycle carry chain stays CHUNK bits long regardless of WIDTH.
module adder_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int CHUNK = ADDER_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_params
        $fatal(1, "adder_pipe: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)",
               WIDTH, CHUNK);
    end

    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic             carry_q [STAGES];
    logic             cmsb_q  [STAGES];
    logic             zero_q  [STAGES];
    logic             valid_q [STAGES];

    logic [WIDTH-1:0] a_in    [STAGES];
    logic [WIDTH-1:0] b_in    [STAGES];
    logic [WIDTH-1:0] sum_in  [STAGES];
    logic [WIDTH-1:0] sum_nxt [STAGES];
    logic             c_in    [STAGES];
    logic             z_in    [STAGES];
    logic             v_in    [STAGES];
    logic [CHUNK-1:0] s_slice [STAGES];
    logic             c_out   [STAGES];
    logic             c_msb   [STAGES];
    logic             z_nxt   [STAGES];

    logic         advance;
    adder_flags_t flags;

    function automatic logic [WIDTH-1:0] insert_slice(
        input logic [WIDTH-1:0] word,
        input logic [CHUNK-1:0] slice,
        input int               idx
    );
        logic [WIDTH-1:0] r;
        r = word;
        r[idx*CHUNK +: CHUNK] = slice;
        return r;
    endfunction

    // Global stall: the whole pipe freezes while a result waits downstream.
    assign advance  = !valid_q[LAST] || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_in[k]   = a;
            assign b_in[k]   = sub ? ~b : b;
            assign c_in[k]   = sub ? ~cin : cin;
            assign z_in[k]   = 1'b1;
            assign v_in[k]   = in_valid;
            assign sum_in[k] = '0;
        end else begin : g_tail
            assign a_in[k]   = a_q[k-1];
            assign b_in[k]   = b_q[k-1];
            assign c_in[k]   = carry_q[k-1];
            assign z_in[k]   = zero_q[k-1];
            assign v_in[k]   = valid_q[k-1];
            assign sum_in[k] = sum_q[k-1];
        end

        adder_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a     (a_in[k][k*CHUNK +: CHUNK]),
            .b     (b_in[k][k*CHUNK +: CHUNK]),
            .cin   (c_in[k]),
            .sum   (s_slice[k]),
            .cout  (c_out[k]),
            .c_msb (c_msb[k])
        );

        assign sum_nxt[k] = insert_slice(sum_in[k], s_slice[k], k);
        assign z_nxt[k]   = z_in[k] && (s_slice[k] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
                cmsb_q[k]  <= 1'b0;
                zero_q[k]  <= 1'b0;
                valid_q[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= a_in[k];
                b_q[k]     <= b_in[k];
                sum_q[k]   <= sum_nxt[k];
                carry_q[k] <= c_out[k];
                cmsb_q[k]  <= c_msb[k];
                zero_q[k]  <= z_nxt[k];
                valid_q[k] <= v_in[k];
            end
        end
    end

    assign flags.cout = carry_q[LAST];
    assign flags.ovf  = carry_q[LAST] ^ cmsb_q[LAST];
    assign flags.zero = zero_q[LAST];
    assign flags.neg  = sum_q[LAST][WIDTH-1];

    assign out_valid = valid_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = flags.cout;
    assign ovf       = flags.ovf;
    assign zero      = flags.zero;
    assign neg       = flags.neg;

endmodule
